// File: rtl/out_port_demux_4x8_pkg.sv
// Shared constants and types for the 4-port output demux.
//   WIDTH   : data width of the CPU byte and each port register
//   CNT_W   : width of each per-port transfer counter (wraps)
//   NPORTS  : number of output ports
//   SEL_W   : width of the port-select field
//   slot_state_e : per-port holding register state
package out_port_demux_4x8_pkg;

  localparam int WIDTH  = 8;
  localparam int CNT_W  = 8;
  localparam int NPORTS = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/out_port_demux_4x8_if.sv
// Handshake bundle between the CPU write path, the demux and the four
// output peripherals.
//   in_valid/in_sel/in_data/in_ready : CPU offer and stall
//   out_data0..3/out_valid/out_ack    : per-port held byte, valid and consume
// master = CPU and peripherals side, slave = the demux.
interface out_port_demux_4x8_if
  import out_port_demux_4x8_pkg::*;
#(
  parameter int W = WIDTH
);
  logic              in_valid;
  logic [SEL_W-1:0]  in_sel;
  logic [W-1:0]      in_data;
  logic              in_ready;
  logic [W-1:0]      out_data0;
  logic [W-1:0]      out_data1;
  logic [W-1:0]      out_data2;
  logic [W-1:0]      out_data3;
  logic [NPORTS-1:0] out_valid;
  logic [NPORTS-1:0] out_ack;

  modport master (
    output in_valid, in_sel, in_data, out_ack,
    input  in_ready, out_data0, out_data1, out_data2, out_data3, out_valid
  );

  modport slave (
    input  in_valid, in_sel, in_data, out_ack,
    output in_ready, out_data0, out_data1, out_data2, out_data3, out_valid
  );
endinterface

// File: rtl/out_port_demux_4x8_slot.sv
// One output-port holding register with its EMPTY/FULL FSM and
// completed-transfer counter.
//   clk, rst  : clock, synchronous active-high reset
//   wr_en     : decoded, already-accepted write strobe for this port
//   wr_data   : byte to load
//   ack       : peripheral consume request
//   data      : held byte
//   valid     : port holds an unconsumed byte
//   xfer_cnt  : completed deliveries (wraps)
//   ack_err   : single-cycle pulse, ack seen while EMPTY
//
// state | meaning
// EMPTY | no byte held, valid=0
// FULL  | byte held and offered to the peripheral, valid=1
module out_port_demux_4x8_slot
  import out_port_demux_4x8_pkg::*;
#(
  parameter int W  = WIDTH,
  parameter int CW = CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          ack,
  output logic [W-1:0]  data,
  output logic          valid,
  output logic [CW-1:0] xfer_cnt,
  output logic          ack_err
);

  slot_state_e state_q, state_d;
  logic        consume;

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    consume = 1'b0;
    ack_err = 1'b0;
    case (state_q)
      EMPTY: begin
        ack_err = ack;
        if (wr_en) state_d = FULL;
      end
      FULL: begin
        consume = ack;
        // a write in the same cycle as the consume keeps the port full
        if (wr_en)    state_d = FULL;
        else if (ack) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data     <= '0;
      xfer_cnt <= '0;
    end else begin
      if (wr_en)   data     <= wr_data;
      if (consume) xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

  assign valid = (state_q == FULL);

endmodule

// File: rtl/out_port_demux_4x8.sv
// Routes one CPU byte per cycle into one of four output-port holding
// registers and stalls the CPU while the selected port is occupied.
//   clk, rst      : clock, synchronous active-high reset
//   bus           : CPU offer / per-port handshake bundle (slave side)
//   xfer_cnt0..3  : completed deliveries per port
//   ack_err       : sticky, an ack arrived on an empty port
module out_port_demux_4x8
  import out_port_demux_4x8_pkg::*;
#(
  parameter int W  = WIDTH,
  parameter int CW = CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  out_port_demux_4x8_if.slave bus,
  output logic [CW-1:0]       xfer_cnt0,
  output logic [CW-1:0]       xfer_cnt1,
  output logic [CW-1:0]       xfer_cnt2,
  output logic [CW-1:0]       xfer_cnt3,
  output logic                ack_err
);

  logic [NPORTS-1:0] slot_valid;
  logic [NPORTS-1:0] slot_err;
  logic [NPORTS-1:0] wr_strobe;
  logic [W-1:0]      slot_data [NPORTS];
  logic [CW-1:0]     slot_cnt  [NPORTS];
  logic              accept;

  // a full port can take a new byte in the same cycle it is being consumed
  assign bus.in_ready = !slot_valid[bus.in_sel] || bus.out_ack[bus.in_sel];
  assign accept       = bus.in_valid && bus.in_ready;

  for (genvar i = 0; i < NPORTS; i++) begin : g_slot
    assign wr_strobe[i] = accept && (bus.in_sel == SEL_W'(i));

    out_port_demux_4x8_slot #(.W(W), .CW(CW)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_strobe[i]),
      .wr_data  (bus.in_data),
      .ack      (bus.out_ack[i]),
      .data     (slot_data[i]),
      .valid    (slot_valid[i]),
      .xfer_cnt (slot_cnt[i]),
      .ack_err  (slot_err[i])
    );
  end

  assign bus.out_valid = slot_valid;
  assign bus.out_data0 = slot_data[0];
  assign bus.out_data1 = slot_data[1];
  assign bus.out_data2 = slot_data[2];
  assign bus.out_data3 = slot_data[3];
  assign xfer_cnt0     = slot_cnt[0];
  assign xfer_cnt1     = slot_cnt[1];
  assign xfer_cnt2     = slot_cnt[2];
  assign xfer_cnt3     = slot_cnt[3];

  always_ff @(posedge clk) begin
    if (rst)            ack_err <= 1'b0;
    else if (|slot_err) ack_err <= 1'b1;
  end

endmodule

// File: tb/tb_out_port_demux_4x8.sv
module tb_out_port_demux_4x8;
  import out_port_demux_4x8_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic [CNT_W-1:0] xfer_cnt0, xfer_cnt1, xfer_cnt2, xfer_cnt3;
  logic ack_err;

  out_port_demux_4x8_if bus ();

  out_port_demux_4x8 dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .xfer_cnt0 (xfer_cnt0),
    .xfer_cnt1 (xfer_cnt1),
    .xfer_cnt2 (xfer_cnt2),
    .xfer_cnt3 (xfer_cnt3),
    .ack_err   (ack_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: what each port holds, how many bytes it delivered
  logic [7:0] m_data  [4];
  logic       m_valid [4];
  int         m_cnt   [4];
  logic       m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] dut_data(input int i);
    case (i)
      0: return bus.out_data0;
      1: return bus.out_data1;
      2: return bus.out_data2;
      default: return bus.out_data3;
    endcase
  endfunction

  function automatic logic [7:0] dut_cnt(input int i);
    case (i)
      0: return xfer_cnt0;
      1: return xfer_cnt1;
      2: return xfer_cnt2;
      default: return xfer_cnt3;
    endcase
  endfunction

  // One clock cycle: drive, check in_ready, advance model, check state.
  task automatic step(input logic v, input logic [1:0] sel, input logic [7:0] d,
                      input logic [3:0] ack, input logic r);
    logic rdy;
    @(negedge clk);
    bus.in_valid = v;
    bus.in_sel   = sel;
    bus.in_data  = d;
    bus.out_ack  = ack;
    rst          = r;
    #1;
    rdy = !m_valid[sel] || ack[sel];
    check("in_ready", bus.in_ready, rdy);
    if (r) begin
      for (int i = 0; i < 4; i++) begin
        m_valid[i] = 1'b0; m_data[i] = 8'h00; m_cnt[i] = 0;
      end
      m_err = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (ack[i] && m_valid[i]) begin
          m_valid[i] = 1'b0;
          m_cnt[i]   = (m_cnt[i] + 1) % 256;
        end else if (ack[i]) begin
          m_err = 1'b1;
        end
      end
      if (v && rdy) begin
        m_data[sel]  = d;
        m_valid[sel] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("valid%0d", i), bus.out_valid[i], m_valid[i]);
      check($sformatf("data%0d", i), dut_data(i), m_data[i]);
      check($sformatf("cnt%0d", i), dut_cnt(i), m_cnt[i][7:0]);
    end
    check("ack_err", ack_err, m_err);
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sel   = 2'd0;
    bus.in_data  = 8'h00;
    bus.out_ack  = 4'b0000;
    rst          = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0; m_data[i] = 8'h00; m_cnt[i] = 0;
    end
    m_err = 1'b0;

    // reset then idle, in_ready for every select
    step(1'b0, 2'd0, 8'h00, 4'b0000, 1'b1);
    step(1'b0, 2'd0, 8'h00, 4'b0000, 1'b1);
    for (int s = 0; s < 4; s++) step(1'b0, 2'(s), 8'h00, 4'b0000, 1'b0);
    check("rst_valid", bus.out_valid, 4'b0000);

    // single write to port 2, consume a few cycles later
    step(1'b1, 2'd2, 8'hA5, 4'b0000, 1'b0);
    check("wr_valid", bus.out_valid, 4'b0100);
    check("wr_data2", bus.out_data2, 8'hA5);
    idle();
    step(1'b0, 2'd0, 8'h00, 4'b0100, 1'b0);
    check("rd_valid", bus.out_valid, 4'b0000);
    check("rd_cnt2", xfer_cnt2, 8'd1);

    // backpressure on port 1, then write-through with ack
    step(1'b1, 2'd1, 8'h11, 4'b0000, 1'b0);
    step(1'b1, 2'd1, 8'h22, 4'b0000, 1'b0);
    check("bp_data1", bus.out_data1, 8'h11);
    step(1'b1, 2'd1, 8'h22, 4'b0010, 1'b0);
    check("wt_data1", bus.out_data1, 8'h22);
    check("wt_valid1", bus.out_valid[1], 1'b1);
    check("wt_cnt1", xfer_cnt1, 8'd1);

    // streaming into port 3 with ack held
    for (int k = 1; k <= 5; k++) step(1'b1, 2'd3, 8'(k), 4'b1000, 1'b0);
    step(1'b0, 2'd3, 8'h00, 4'b1000, 1'b0);
    check("stream_cnt3", xfer_cnt3, 8'd5);

    // ack on empty port 0 sets sticky error
    step(1'b0, 2'd0, 8'h00, 4'b0001, 1'b0);
    idle();
    check("err_sticky", ack_err, 1'b1);

    // 256 deliveries on port 0 wrap its counter
    for (int k = 0; k < 257; k++) step(1'b1, 2'd0, 8'(k), 4'b0001, 1'b0);
    step(1'b0, 2'd0, 8'h00, 4'b0001, 1'b0);
    check("wrap_cnt0", xfer_cnt0, 8'd1);

    // reset mid-operation with offer and acks present
    step(1'b1, 2'd0, 8'h3C, 4'b0000, 1'b0);
    step(1'b1, 2'd3, 8'hC3, 4'b0000, 1'b0);
    step(1'b1, 2'd2, 8'h77, 4'b1001, 1'b1);
    check("mid_rst_valid", bus.out_valid, 4'b0000);
    check("mid_rst_err", ack_err, 1'b0);

    // randomized traffic against the model
    for (int k = 0; k < 2000; k++) begin
      logic [3:0] a;
      a = 4'($urandom) & 4'($urandom);
      step(1'($urandom), 2'($urandom), 8'($urandom), a, ($urandom_range(0, 63) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
